// File: rtl/tmr_pkg.sv
// Shared definitions for the TMR scrubber.
//   state_t  : scrubber FSM states
//   ERR_NONE : voter error vector when all three lanes agree
//   ERR_ALL  : voter error vector when no two lanes agree (no majority)
package tmr_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_WAIT = 3'd1,
        ST_REQ  = 3'd2,
        ST_READ = 3'd3,
        ST_CAPT = 3'd4,
        ST_VOTE = 3'd5,
        ST_FIX  = 3'd6
    } state_t;

    localparam logic [2:0] ERR_NONE = 3'b000;
    localparam logic [2:0] ERR_ALL  = 3'b111;

endpackage

// File: rtl/word_voter.sv
// Word-level triple-modular-redundancy voter.
//   a, b, c : the three lane copies of one word
//   voted   : bitwise majority of the three lanes
//   error   : error[i] set when lane i differs from both other lanes.
//             Possible results are 000, a single set bit, or 111.
module word_voter #(
    parameter int N = 32
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic [N-1:0] c,
    output logic [N-1:0] voted,
    output logic [2:0]   error
);

    logic ab_eq;
    logic ac_eq;
    logic bc_eq;

    always_comb begin
        ab_eq    = (a == b);
        ac_eq    = (a == c);
        bc_eq    = (b == c);
        error[0] = !ab_eq && !ac_eq;
        error[1] = !ab_eq && !bc_eq;
        error[2] = !ac_eq && !bc_eq;
        voted    = (a & b) | (a & c) | (b & c);
    end

endmodule

// File: rtl/tmr_scrubber.sv
// Background scrubber for a triplicated word memory.
// Walks every address, reads all three lane copies, votes them and writes the
// voted word back into a single disagreeing lane. Counts corrections per lane
// and raises a sticky fail flag once a lane reaches ERR_THRESH corrections.
//
// Ports:
//   clk, reset     : clock, asynchronous active-high reset
//   enable         : scrubbing allowed (an entry in progress always completes)
//   clr_stats      : synchronous clear of err_cnt and lane_fail
//   mem_req/gnt    : memory port request / arbiter grant
//   mem_addr       : address for read and write-back
//   mem_rd         : read strobe for all three lanes; data one cycle later
//   mem_rdata      : lane data [lane][bit]
//   mem_wr         : per-lane write enable
//   mem_wdata      : voted word for write-back
//   err_cnt        : per-lane saturating correction counters [lane][7:0]
//   lane_fail      : sticky per-lane fail flags
//   uncorrectable  : one-cycle pulse, no majority at mem_addr
//   pass_done      : one-cycle pulse when the address wraps DEPTH-1 -> 0
//
// Memory handshake: mem_req is held from REQ through the end of the entry and
// mem_addr is stable while it is high. The arbiter holds mem_gnt for as long
// as mem_req is high; if mem_gnt drops after the grant, the entry is abandoned
// with no write and retried at the same address after the interval.
module tmr_scrubber
    import tmr_pkg::*;
#(
    parameter int N          = 32,
    parameter int DEPTH      = 32,
    parameter int ADDR_W     = $clog2(DEPTH),
    parameter int INTERVAL   = 16,
    parameter int ERR_THRESH = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 enable,
    input  logic                 clr_stats,
    output logic                 mem_req,
    input  logic                 mem_gnt,
    output logic [ADDR_W-1:0]    mem_addr,
    output logic                 mem_rd,
    input  logic [2:0][N-1:0]    mem_rdata,
    output logic [2:0]           mem_wr,
    output logic [N-1:0]         mem_wdata,
    output logic [2:0][7:0]      err_cnt,
    output logic [2:0]           lane_fail,
    output logic                 uncorrectable,
    output logic                 pass_done
);

    localparam int CNT_W = (INTERVAL > 1) ? $clog2(INTERVAL) : 1;
    localparam logic [CNT_W-1:0]  CNT_LOAD  = CNT_W'(INTERVAL - 1);
    localparam logic [ADDR_W-1:0] ADDR_LAST = ADDR_W'(DEPTH - 1);
    localparam logic [7:0]        THRESH    = 8'(ERR_THRESH);

    state_t              state, state_nxt;
    logic [CNT_W-1:0]    cnt, cnt_nxt;
    logic [ADDR_W-1:0]   addr, addr_nxt;
    logic [2:0][N-1:0]   lane_q;
    logic [2:0]          err_q;
    logic [N-1:0]        voted;
    logic [2:0]          vote_err;
    logic                advance;
    logic                fix_now;

    word_voter #(.N(N)) u_voter (
        .a     (lane_q[0]),
        .b     (lane_q[1]),
        .c     (lane_q[2]),
        .voted (voted),
        .error (vote_err)
    );

    // Next-state logic. Every path that ends an entry (clean, uncorrectable or
    // fixed) advances the address; a lost grant returns to WAIT at the same one.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        addr_nxt  = addr;
        advance   = 1'b0;
        unique case (state)
            ST_IDLE: begin
                if (enable) begin
                    cnt_nxt   = CNT_LOAD;
                    state_nxt = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (cnt == '0) begin
                    state_nxt = enable ? ST_REQ : ST_IDLE;
                end else begin
                    cnt_nxt = cnt - 1'b1;
                end
            end
            ST_REQ: begin
                if (mem_gnt) state_nxt = ST_READ;
            end
            ST_READ, ST_CAPT: begin
                if (!mem_gnt) begin
                    cnt_nxt   = CNT_LOAD;
                    state_nxt = ST_WAIT;
                end else begin
                    state_nxt = (state == ST_READ) ? ST_CAPT : ST_VOTE;
                end
            end
            ST_VOTE, ST_FIX: begin
                if (!mem_gnt) begin
                    cnt_nxt   = CNT_LOAD;
                    state_nxt = ST_WAIT;
                end else if (state == ST_VOTE && vote_err != ERR_NONE
                             && vote_err != ERR_ALL) begin
                    state_nxt = ST_FIX;
                end else begin
                    advance = 1'b1;
                    if (enable) begin
                        cnt_nxt   = CNT_LOAD;
                        state_nxt = ST_WAIT;
                    end else begin
                        state_nxt = ST_IDLE;
                    end
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
        if (advance) begin
            addr_nxt = (addr == ADDR_LAST) ? '0 : addr + 1'b1;
        end
    end

    // Outputs decode directly from state so reset clears them immediately.
    always_comb begin
        mem_req       = (state == ST_REQ) || (state == ST_READ) || (state == ST_CAPT)
                        || (state == ST_VOTE) || (state == ST_FIX);
        mem_rd        = (state == ST_READ) && mem_gnt;
        fix_now       = (state == ST_FIX) && mem_gnt;
        mem_wr        = fix_now ? err_q : 3'b000;
        uncorrectable = (state == ST_VOTE) && mem_gnt && (vote_err == ERR_ALL);
        pass_done     = advance && (addr == ADDR_LAST);
        mem_addr      = addr;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= ST_IDLE;
            cnt       <= '0;
            addr      <= '0;
            lane_q    <= '0;
            err_q     <= '0;
            mem_wdata <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            addr  <= addr_nxt;
            if (state == ST_CAPT) lane_q <= mem_rdata;
            if (state == ST_VOTE) begin
                mem_wdata <= voted;
                err_q     <= vote_err;
            end
        end
    end

    // Correction statistics. A clear in the same cycle as a fix wins.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            err_cnt   <= '0;
            lane_fail <= '0;
        end else if (clr_stats) begin
            err_cnt   <= '0;
            lane_fail <= '0;
        end else if (fix_now) begin
            for (int i = 0; i < 3; i++) begin
                if (err_q[i] && err_cnt[i] != 8'hFF) begin
                    err_cnt[i] <= err_cnt[i] + 8'd1;
                    if (err_cnt[i] + 8'd1 >= THRESH) lane_fail[i] <= 1'b1;
                end
            end
        end
    end

endmodule
